// File: rtl/optical_flow_host_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : optical_flow_host_ctrl                                       |
// | Description : Host-side controller for the optical_flow_hls core. Loads    |
// |               camera frames into ping-pong image banks, serves the core's  |
// |               img/prev read ports, runs the ap_ctrl_hs start handshake,    |
// |               captures flow writes and drains the flow field to the host.  |
// | Option      : OPTICAL_FLOW_HOST_WATCHDOG_EN adds a START/RUN watchdog and  |
// |               a sticky ERR state.                                          |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module optical_flow_host_ctrl #(
   parameter int IMG_DEPTH      = 1024,
   parameter int FLOW_DEPTH     = 2048,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          pix_valid,
   output logic                          pix_ready,
   input  logic [DATA_W-1:0]             pix_data,
   output logic                          flow_valid,
   input  logic                          flow_ready,
   output logic [DATA_W-1:0]             flow_data,
   output logic                          flow_last,
   output logic                          busy,
   output logic [15:0]                   frames_done,
   output logic                          err,
   output logic                          ap_start,
   input  logic                          ap_done,
   input  logic                          ap_idle,
   input  logic                          ap_ready,
   input  logic                          img_ce0,
   input  logic [$clog2(IMG_DEPTH)-1:0]  img_address0,
   output logic [DATA_W-1:0]             img_q0,
   input  logic                          prev_ce0,
   input  logic [$clog2(IMG_DEPTH)-1:0]  prev_address0,
   output logic [DATA_W-1:0]             prev_q0,
   input  logic                          flow_ce0,
   input  logic                          flow_we0,
   input  logic [$clog2(FLOW_DEPTH)-1:0] flow_address0,
   input  logic [DATA_W-1:0]             flow_d0
);

   localparam int IA_W = $clog2(IMG_DEPTH);
   localparam int FA_W = $clog2(FLOW_DEPTH);
   localparam logic [IA_W-1:0] LOAD_LAST = IA_W'(IMG_DEPTH - 1);
   localparam logic [FA_W-1:0] FLOW_LAST = FA_W'(FLOW_DEPTH - 1);

`ifdef OPTICAL_FLOW_HOST_WATCHDOG_EN
   typedef enum logic [2:0] {LOAD, START, RUN, DRAIN, ERR} state_t;
`else
   typedef enum logic [2:0] {LOAD, START, RUN, DRAIN} state_t;
`endif

   state_t state, next_state;

   // Storage: two image banks and the flow buffer (contents never reset)
   logic [DATA_W-1:0] bank_a   [IMG_DEPTH];
   logic [DATA_W-1:0] bank_b   [IMG_DEPTH];
   logic [DATA_W-1:0] flow_mem [FLOW_DEPTH];

   logic            cur;
   logic            prev_valid;
   logic [IA_W-1:0] load_cnt;

   // Drain pipeline: one prefetch register in front of the output register
   logic [FA_W:0]     rd_cnt;
   logic              pf_valid;
   logic              pf_last;
   logic [DATA_W-1:0] pf_data;

   logic load_fire, load_at_end, in_drain, out_load, rd_issue, final_accept;
   logic flow_commit, timeout;

   // ap_idle is status-only; nothing in the controller depends on it
   logic unused_idle;
   assign unused_idle = ap_idle;

   assign load_fire    = pix_valid & pix_ready;
   assign load_at_end  = (load_cnt == LOAD_LAST);
   assign in_drain     = (state == DRAIN);
   assign out_load     = pf_valid & (~flow_valid | flow_ready);
   assign rd_issue     = in_drain & ~rd_cnt[FA_W] & (~pf_valid | out_load);
   assign final_accept = flow_valid & flow_ready & flow_last;
   assign flow_commit  = flow_ce0 & flow_we0 & ((state == START) | (state == RUN));

   assign ap_start = (state == START);
   assign busy     = (state == START) | (state == RUN) | (state == DRAIN);

`ifdef OPTICAL_FLOW_HOST_WATCHDOG_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
   logic [WD_W-1:0] wd_cnt;

   assign timeout = (wd_cnt == WD_LAST);
   assign err     = (state == ERR);

   // Watchdog restarts on every entry to START and runs while the core owns the frame
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wd_cnt <= '0;
      end else if ((state != START) && (next_state == START)) begin
         wd_cnt <= '0;
      end else if ((state == START) || (state == RUN)) begin
         wd_cnt <= wd_cnt + 1'b1;
      end
   end
`else
   localparam int unused_timeout = TIMEOUT_CYCLES;
   assign timeout = 1'b0;
   assign err     = 1'b0;
`endif

   // Next-state logic; ap_done only matters once the core has taken the start
   always_comb begin
      next_state = state;
      case (state)
         LOAD: begin
            if (load_fire && load_at_end && prev_valid) next_state = START;
         end
         START: begin
`ifdef OPTICAL_FLOW_HOST_WATCHDOG_EN
            if (timeout) next_state = ERR;
            else
`endif
            if (ap_ready) next_state = ap_done ? DRAIN : RUN;
         end
         RUN: begin
`ifdef OPTICAL_FLOW_HOST_WATCHDOG_EN
            if (timeout) next_state = ERR;
            else
`endif
            if (ap_done) next_state = DRAIN;
         end
         DRAIN: begin
            if (final_accept) next_state = LOAD;
         end
`ifdef OPTICAL_FLOW_HOST_WATCHDOG_EN
         ERR: next_state = ERR;
`endif
         default: next_state = LOAD;
      endcase
   end

   // State register, bank select, load counter and frame counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= LOAD;
         pix_ready   <= 1'b0;
         cur         <= 1'b0;
         prev_valid  <= 1'b0;
         load_cnt    <= '0;
         frames_done <= '0;
      end else begin
         state     <= next_state;
         pix_ready <= (next_state == LOAD);
         if (load_fire) begin
            load_cnt <= load_cnt + 1'b1;
            // First frame after reset only primes the prev bank
            if (load_at_end && !prev_valid) begin
               cur        <= ~cur;
               prev_valid <= 1'b1;
            end
         end
         if (final_accept) begin
            cur         <= ~cur;
            frames_done <= frames_done + 1'b1;
         end
      end
   end

   // Frame loading writes the current bank
   always_ff @(posedge clk) begin
      if (load_fire) begin
         if (cur) bank_b[load_cnt] <= pix_data;
         else     bank_a[load_cnt] <= pix_data;
      end
   end

   // Core image read ports: one-cycle latency, output holds when ce0 is low
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         img_q0  <= '0;
         prev_q0 <= '0;
      end else begin
         if (img_ce0)  img_q0  <= cur ? bank_b[img_address0]  : bank_a[img_address0];
         if (prev_ce0) prev_q0 <= cur ? bank_a[prev_address0] : bank_b[prev_address0];
      end
   end

   // Flow buffer: core writes while it runs, drain reads into the prefetch register
   always_ff @(posedge clk) begin
      if (flow_commit) flow_mem[flow_address0] <= flow_d0;
      if (rd_issue)    pf_data <= flow_mem[rd_cnt[FA_W-1:0]];
   end

   // Drain sequencing: issue reads only when the prefetch slot will be free
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_cnt     <= '0;
         pf_valid   <= 1'b0;
         pf_last    <= 1'b0;
         flow_valid <= 1'b0;
         flow_data  <= '0;
         flow_last  <= 1'b0;
      end else if (!in_drain) begin
         rd_cnt     <= '0;
         pf_valid   <= 1'b0;
         flow_valid <= 1'b0;
         flow_last  <= 1'b0;
      end else begin
         if (rd_issue) begin
            rd_cnt   <= rd_cnt + 1'b1;
            pf_last  <= (rd_cnt[FA_W-1:0] == FLOW_LAST);
            pf_valid <= 1'b1;
         end else if (out_load) begin
            pf_valid <= 1'b0;
         end
         if (out_load) begin
            flow_valid <= 1'b1;
            flow_data  <= pf_data;
            flow_last  <= pf_last;
         end else if (flow_valid && flow_ready) begin
            flow_valid <= 1'b0;
            flow_last  <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_optical_flow_host_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_optical_flow_host_ctrl                                    |
// | Description : Directed self-checking bench for optical_flow_host_ctrl.     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_optical_flow_host_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        pix_valid, pix_ready;
   logic [31:0] pix_data;
   logic        flow_valid, flow_ready, flow_last;
   logic [31:0] flow_data;
   logic        busy, err, ap_start, ap_done, ap_idle, ap_ready;
   logic [15:0] frames_done;
   logic        img_ce0, prev_ce0, flow_ce0, flow_we0;
   logic [9:0]  img_address0, prev_address0;
   logic [10:0] flow_address0;
   logic [31:0] img_q0, prev_q0, flow_d0;

   int errors = 0;
   int checks = 0;
   int ap_start_rises = 0;
   logic ap_start_q = 1'b0;

   always #5 clk = ~clk;

   optical_flow_host_ctrl #(
      .IMG_DEPTH(1024), .FLOW_DEPTH(2048), .DATA_W(32), .TIMEOUT_CYCLES(100)
   ) dut (
      .clk(clk), .rst(rst),
      .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
      .flow_valid(flow_valid), .flow_ready(flow_ready), .flow_data(flow_data),
      .flow_last(flow_last), .busy(busy), .frames_done(frames_done), .err(err),
      .ap_start(ap_start), .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
      .img_ce0(img_ce0), .img_address0(img_address0), .img_q0(img_q0),
      .prev_ce0(prev_ce0), .prev_address0(prev_address0), .prev_q0(prev_q0),
      .flow_ce0(flow_ce0), .flow_we0(flow_we0), .flow_address0(flow_address0),
      .flow_d0(flow_d0)
   );

   // Count ap_start pulses, sampled away from the active edge
   always @(negedge clk) begin
      if (ap_start && !ap_start_q) ap_start_rises++;
      ap_start_q = ap_start;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic load_frame(input string tag, input int base);
      int  n = 0;
      int  guard = 0;
      bit  acc;
      while (n < 1024 && guard < 20000) begin
         pix_valid = ($urandom_range(0, 3) != 0);
         pix_data  = 32'(base + n);
         acc = pix_valid && pix_ready;
         tick();
         if (acc) n++;
         guard++;
      end
      pix_valid = 1'b0;
      chk({tag, "_words"}, 32'(n), 32'd1024);
   endtask

   task automatic core_write(input int mul, input int skip);
      for (int a = 0; a < 2048; a++) begin
         flow_ce0      = 1'b1;
         flow_we0      = (a != skip);
         flow_address0 = 11'(a);
         flow_d0       = 32'(mul * a);
         tick();
      end
      flow_ce0 = 1'b0;
      flow_we0 = 1'b0;
   endtask

   task automatic drain(input string tag, input int mul, input int skip, input int skip_val,
                        input bit bp, output int cycles);
      int idx = 0;
      int bad = 0;
      int guard = 0;
      logic [31:0] exp;
      logic [31:0] held;
      bit hold_chk = 0;
      while (idx < 2048 && guard < 30000) begin
         flow_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
         if (hold_chk && (flow_data !== held || flow_valid !== 1'b1)) bad++;
         hold_chk = 0;
         if (flow_valid && flow_ready) begin
            exp = (idx == skip) ? 32'(skip_val) : 32'(mul * idx);
            if (flow_data !== exp || flow_last !== (idx == 2047)) bad++;
            idx++;
         end else if (flow_valid) begin
            held = flow_data;
            hold_chk = 1;
         end
         tick();
         guard++;
      end
      flow_ready = 1'b0;
      cycles = guard;
      chk({tag, "_words"}, 32'(idx), 32'd2048);
      chk({tag, "_bad"}, 32'(bad), 32'd0);
   endtask

   initial begin
      int cyc;
      int hi;
      rst = 1'b0;
      pix_valid = 1'b0; pix_data = '0;
      flow_ready = 1'b0;
      ap_done = 1'b0; ap_idle = 1'b1; ap_ready = 1'b0;
      img_ce0 = 1'b0; prev_ce0 = 1'b0; img_address0 = '0; prev_address0 = '0;
      flow_ce0 = 1'b0; flow_we0 = 1'b0; flow_address0 = '0; flow_d0 = '0;

      // Reset values
      tick(); tick();
      chk("rst_pix_ready", pix_ready, 0);
      chk("rst_ap_start", ap_start, 0);
      chk("rst_flow_valid", flow_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      chk("rst_frames", frames_done, 0);
      chk("rst_flow_data", flow_data, 0);
      chk("rst_flow_last", flow_last, 0);
      chk("rst_img_q0", img_q0, 0);
      chk("rst_prev_q0", prev_q0, 0);
      rst = 1'b1;
      tick();
      chk("rel_pix_ready", pix_ready, 1);

      // Run 1: prime frame, then current frame
      load_frame("f1", 0);
      chk("f1_stay_load", pix_ready, 1);
      chk("f1_no_start", ap_start, 0);
      load_frame("f2", 1000);
      chk("f2_pix_ready", pix_ready, 0);
      chk("f2_ap_start", ap_start, 1);
      chk("f2_busy", busy, 1);

      img_ce0 = 1; prev_ce0 = 1; img_address0 = 10'd5; prev_address0 = 10'd5;
      tick();
      chk("r1_img_q0", img_q0, 1005);
      chk("r1_prev_q0", prev_q0, 5);
      img_ce0 = 0; prev_ce0 = 0; img_address0 = 10'd9; prev_address0 = 10'd9;
      tick();
      chk("r1_img_hold", img_q0, 1005);
      chk("r1_prev_hold", prev_q0, 5);

      // ap_ready low for 10 cycles keeps ap_start high
      hi = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (ap_start === 1'b1) hi++;
      end
      chk("r1_start_held", 32'(hi), 32'd10);
      ap_ready = 1'b1;
      tick();
      ap_ready = 1'b0;
      chk("r1_start_drop", ap_start, 0);
      chk("r1_run_busy", busy, 1);
      chk("r1_start_once", 32'(ap_start_rises), 32'd1);

      core_write(3, -1);
      ap_done = 1'b1;
      tick();
      ap_done = 1'b0;
      chk("r1_d0_busy", busy, 1);
      chk("r1_d0_valid", flow_valid, 0);
      tick();
      chk("r1_d1_valid", flow_valid, 0);
      tick();
      chk("r1_d2_valid", flow_valid, 1);
      drain("r1_drain", 3, -1, 0, 1'b1, cyc);
      chk("r1_end_valid", flow_valid, 0);
      chk("r1_end_pix_ready", pix_ready, 1);
      chk("r1_end_busy", busy, 0);
      chk("r1_frames", frames_done, 1);

      // Run 2: dropped write during LOAD, ap_ready and ap_done together
      flow_ce0 = 1; flow_we0 = 1; flow_address0 = 11'd7; flow_d0 = 32'hDEAD;
      tick();
      flow_ce0 = 0; flow_we0 = 0;
      load_frame("f3", 2000);
      chk("f3_ap_start", ap_start, 1);
      img_ce0 = 1; prev_ce0 = 1; img_address0 = 10'd5; prev_address0 = 10'd5;
      tick();
      img_ce0 = 0; prev_ce0 = 0;
      chk("r2_img_q0", img_q0, 2005);
      chk("r2_prev_q0", prev_q0, 1005);
      core_write(5, 7);
      ap_ready = 1'b1; ap_done = 1'b1;
      tick();
      ap_ready = 1'b0; ap_done = 1'b0;
      chk("r2_direct_start", ap_start, 0);
      chk("r2_direct_busy", busy, 1);
      chk("r2_d0_valid", flow_valid, 0);
      tick();
      chk("r2_d1_valid", flow_valid, 0);
      tick();
      chk("r2_d2_valid", flow_valid, 1);
      drain("r2_drain", 5, 7, 21, 1'b0, cyc);
      chk("r2_throughput", 32'(cyc), 32'd2048);
      chk("r2_frames", frames_done, 2);

      // Run 3: reset in the middle of DRAIN
      load_frame("f4", 3000);
      ap_ready = 1'b1; ap_done = 1'b1;
      tick();
      ap_ready = 1'b0; ap_done = 1'b0;
      tick(); tick();
      flow_ready = 1'b1;
      for (int k = 0; k < 5; k++) tick();
      flow_ready = 1'b0;
      #2 rst = 1'b0;
      #1;
      chk("mid_rst_flow_valid", flow_valid, 0);
      chk("mid_rst_flow_data", flow_data, 0);
      chk("mid_rst_flow_last", flow_last, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_frames", frames_done, 0);
      chk("mid_rst_pix_ready", pix_ready, 0);
      chk("mid_rst_img_q0", img_q0, 0);
      chk("mid_rst_prev_q0", prev_q0, 0);
      chk("mid_rst_ap_start", ap_start, 0);
      tick();
      rst = 1'b1;
      tick();
      chk("post_rst_pix_ready", pix_ready, 1);
      chk("start_pulses", 32'(ap_start_rises), 32'd3);
      load_frame("f5", 4000);
      chk("f5_prime_only", ap_start, 0);
      chk("f5_pix_ready", pix_ready, 1);

`ifdef OPTICAL_FLOW_HOST_WATCHDOG_EN
      // Watchdog: no ap_ready/ap_done after START entry
      load_frame("f6", 5000);
      chk("wd_start", ap_start, 1);
      hi = 0;
      for (int k = 0; k < 99; k++) begin
         tick();
         if (err !== 1'b0) hi++;
      end
      chk("wd_early_err", 32'(hi), 32'd0);
      tick();
      chk("wd_err", err, 1);
      chk("wd_pix_ready", pix_ready, 0);
      chk("wd_ap_start", ap_start, 0);
      chk("wd_busy", busy, 0);
      tick(); tick();
      chk("wd_sticky", err, 1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
